// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
//  Shared definitions for the data-RAM arbiter:
//   - state_t : sequencer state encoding (IDLE, ACCESS, WAIT, DONE), 2 bits
//   - PORT_A / PORT_B : requester identifiers as carried in the winner flag
//   - DEF_AW / DEF_DW : default address and data widths
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

endpackage

// File: rtl/ram_arb_pick.sv
// ---------------------------------------------------------------------------
// ram_arb_pick
//  Winner selection and arbitration policy state for ram_arb.
//  Build option: RAM_ARB_RR_EN
//   defined   : round-robin; a last-grant pointer (reset to port B) gives a
//               tie to the port that was not granted last.
//   undefined : fixed priority to port A with starvation relief for port B.
//               After STARVE_MAX consecutive B losses, B wins the next tie.
// Ports
//  clk, reset   : clock, asynchronous active-low reset
//  idle         : sequencer is in IDLE (the only state that arbitrates)
//  req_a, req_b : requests from the two ports
//  win          : combinational winner (PORT_A / PORT_B), valid when upd=1
//  upd          : strobe, high on every IDLE cycle that grants a port
// ---------------------------------------------------------------------------
module ram_arb_pick
  import ram_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic req_a,
  input  logic req_b,
  output logic win,
  output logic upd
);

  assign upd = idle && (req_a || req_b);

`ifdef RAM_ARB_RR_EN

  logic last_reg;

  always_comb begin
    win = PORT_A;
    if (req_a && req_b) begin
      win = ~last_reg;
    end else if (req_b) begin
      win = PORT_B;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_reg <= PORT_B;
    end else if (upd) begin
      last_reg <= win;
    end
  end

`else

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_reg;

  always_comb begin
    win = PORT_A;
    if (req_a && req_b) begin
      win = (starve_cnt_reg == STARVE_LIM) ? PORT_B : PORT_A;
    end else if (req_b) begin
      win = PORT_B;
    end
  end

  // Only a B request that loses counts; the count saturates at the limit and
  // any B grant (contested or not) clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_reg <= 4'd0;
    end else if (upd) begin
      if (win == PORT_B) begin
        starve_cnt_reg <= 4'd0;
      end else if (req_b && (starve_cnt_reg != STARVE_LIM)) begin
        starve_cnt_reg <= starve_cnt_reg + 4'd1;
      end
    end
  end

`endif

endmodule

// File: rtl/ram_arb.sv
// ---------------------------------------------------------------------------
// ram_arb
//  Two-requester arbiter and sequencer for a single-port data RAM.
//  Port A (CPU) has priority; port B (debug/DMA loader) is protected from
//  starvation, or both share round-robin when RAM_ARB_RR_EN is defined
//  (see ram_arb_pick). One access at a time: IDLE -> ACCESS -> [WAIT] -> DONE.
// Parameters
//  AW, DW      : address / data width
//  RD_LAT      : RAM read latency, 1..7. ram_rdata is sampled on the clock
//                edge RD_LAT edges after the one that raised ram_en.
//  STARVE_MAX  : consecutive B losses that force a B grant, 1..15
// Ports
//  clk, reset            : clock, asynchronous active-low reset
//  req_x, we_x           : request (held until ack) and write flag
//  addr_x, wdata_x       : address / write data, sampled at grant
//  gnt_x                 : high from ACCESS through DONE for the winner
//  ack_x                 : one-cycle pulse in DONE
//  rdata_x               : captured read data, held until the next read
//  ram_en, ram_we        : RAM strobe / write enable (high in ACCESS only)
//  ram_addr, ram_wdata   : registered RAM address / write data
//  ram_rdata             : RAM read data
//  busy                  : sequencer not in IDLE
// ---------------------------------------------------------------------------
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          ack_a,
  output logic          ack_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

  state_t        state_reg, state_next;
  logic [2:0]    lat_cnt_reg;
  logic          win_reg;
  logic          we_reg;
  logic          ram_en_reg, ram_we_reg;
  logic [AW-1:0] ram_addr_reg;
  logic [DW-1:0] ram_wdata_reg;
  logic [DW-1:0] rdata_a_reg, rdata_b_reg;
  logic          ack_a_reg, ack_b_reg;

  logic          pick_win, pick_upd;
  logic          we_sel;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;
  logic          capture;

  ram_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk   (clk),
    .reset (reset),
    .idle  (state_reg == IDLE),
    .req_a (req_a),
    .req_b (req_b),
    .win   (pick_win),
    .upd   (pick_upd)
  );

  assign we_sel    = (pick_win == PORT_B) ? we_b    : we_a;
  assign addr_sel  = (pick_win == PORT_B) ? addr_b  : addr_a;
  assign wdata_sel = (pick_win == PORT_B) ? wdata_b : wdata_a;

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pick_upd) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (we_reg || (RD_LAT == 1)) begin
          state_next = DONE;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // lat_cnt enters WAIT at RD_LAT-1, so the last WAIT cycle sees 1
        if (lat_cnt_reg <= 3'd1) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Read data is sampled on the edge that moves the sequencer into DONE, so
  // it is already valid in the ack cycle.
  assign capture = ((state_reg == ACCESS) || (state_reg == WAIT)) &&
                   (state_next == DONE) && !we_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Grant bookkeeping and RAM bus registers. Address/data hold between
  // accesses; only the strobes return to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_reg       <= PORT_A;
      we_reg        <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
    end else if (pick_upd) begin
      win_reg       <= pick_win;
      we_reg        <= we_sel;
      ram_addr_reg  <= addr_sel;
      ram_wdata_reg <= wdata_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_en_reg <= 1'b0;
      ram_we_reg <= 1'b0;
    end else begin
      ram_en_reg <= (state_next == ACCESS);
      ram_we_reg <= (state_next == ACCESS) && we_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt_reg <= 3'd0;
    end else if (state_reg == ACCESS) begin
      lat_cnt_reg <= LAT_INIT;
    end else if ((state_reg == WAIT) && (lat_cnt_reg != 3'd0)) begin
      lat_cnt_reg <= lat_cnt_reg - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_a_reg <= '0;
      rdata_b_reg <= '0;
    end else if (capture) begin
      if (win_reg == PORT_B) begin
        rdata_b_reg <= ram_rdata;
      end else begin
        rdata_a_reg <= ram_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_a_reg <= 1'b0;
      ack_b_reg <= 1'b0;
    end else begin
      ack_a_reg <= (state_next == DONE) && (win_reg == PORT_A);
      ack_b_reg <= (state_next == DONE) && (win_reg == PORT_B);
    end
  end

  assign busy      = (state_reg != IDLE);
  assign gnt_a     = busy && (win_reg == PORT_A);
  assign gnt_b     = busy && (win_reg == PORT_B);
  assign ack_a     = ack_a_reg;
  assign ack_b     = ack_b_reg;
  assign rdata_a   = rdata_a_reg;
  assign rdata_b   = rdata_b_reg;
  assign ram_en    = ram_en_reg;
  assign ram_we    = ram_we_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;

endmodule

// File: tb/tb_ram_arb.sv
// ---------------------------------------------------------------------------
// tb_ram_arb
//  Directed bench for ram_arb (RD_LAT=2, STARVE_MAX=4). Expected acks are
//  queued when a request is driven and popped when an ack appears.
//  Honours RAM_ARB_RR_EN for the expected contested grant order.
// ---------------------------------------------------------------------------
module tb_ram_arb;

  localparam int AW         = 16;
  localparam int DW         = 16;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;

  logic          clk;
  logic          reset;
  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          gnt_a, gnt_b, ack_a, ack_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  ram_arb #(
    .AW (AW), .DW (DW), .RD_LAT (RD_LAT), .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .we_a      (we_a),
    .addr_a    (addr_a),
    .wdata_a   (wdata_a),
    .req_b     (req_b),
    .we_b      (we_b),
    .addr_b    (addr_b),
    .wdata_b   (wdata_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .ack_a     (ack_a),
    .ack_b     (ack_b),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model for RD_LAT=2: one register stage, so data is present in the
  // cycle after ram_en and sampled on the following edge. Outside a read
  // window the bus carries a marker value.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_pipe;
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    rd_pipe <= (ram_en && !ram_we) ? mem[ram_addr[7:0]] : 16'hDEAD;
  end
  assign ram_rdata = rd_pipe;

  typedef struct {
    logic          port;
    logic          we;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   acks  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic we, input logic [DW-1:0] data);
    exp_t e;
    e.port = port;
    e.we   = we;
    e.data = data;
    sb.push_back(e);
  endtask

  // One clock; sample 1 time unit after the edge, check invariants and
  // retire any ack against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    check("gnt_exclusive", {31'd0, gnt_a & gnt_b}, 32'd0);
    check("we_without_en", {31'd0, ram_we & ~ram_en}, 32'd0);
    if (ack_a || ack_b) begin
      acks++;
      if (sb.size() == 0) begin
        check("unexpected_ack", {30'd0, ack_b, ack_a}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_port", {30'd0, ack_b, ack_a}, e.port ? 32'd2 : 32'd1);
        if (!e.we) check("ack_rdata", e.port ? rdata_b : rdata_a, {16'd0, e.data});
        $display("txn %0t port=%s we=%0d rdata_a=%h rdata_b=%h", $time,
                 e.port ? "B" : "A", e.we, rdata_a, rdata_b);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int   a0;
    int   cyc;
    logic exp_port;

    reset = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;

    // Reset state
    #12;
    check("rst_ctrl", {25'd0, gnt_a, gnt_b, ack_a, ack_b, ram_en, ram_we, busy}, 32'd0);
    check("rst_rdata", {rdata_a, rdata_b}, 32'd0);
    check("rst_ram_bus", {ram_addr, ram_wdata}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // 1: write from A alone
    req_a = 1'b1; we_a = 1'b1; addr_a = 16'h0010; wdata_a = 16'hBEEF;
    push(1'b0, 1'b1, 16'h0);
    tick();
    check("t1_en_we", {30'd0, ram_en, ram_we}, 32'd3);
    check("t1_addr", {16'd0, ram_addr}, 32'h0010);
    check("t1_wdata", {16'd0, ram_wdata}, 32'hBEEF);
    check("t1_gnt", {30'd0, gnt_a, gnt_b}, 32'd2);
    check("t1_no_early_ack", {31'd0, ack_a}, 32'd0);
    tick();
    check("t1_ack", {31'd0, ack_a}, 32'd1);
    req_a = 1'b0;
    tick();
    check("t1_idle", {29'd0, busy, ack_a, ram_en}, 32'd0);
    check("t1_addr_hold", {16'd0, ram_addr}, 32'h0010);
    check("t1_mem", {16'd0, mem[8'h10]}, 32'hBEEF);

    // Preload 16'h1234 at 0x20 through port A
    req_a = 1'b1; we_a = 1'b1; addr_a = 16'h0020; wdata_a = 16'h1234;
    push(1'b0, 1'b1, 16'h0);
    tick();
    tick();
    check("pre_ack", {31'd0, ack_a}, 32'd1);
    req_a = 1'b0;
    tick();

    // 2: read from B alone, RD_LAT=2
    req_b = 1'b1; we_b = 1'b0; addr_b = 16'h0020;
    push(1'b1, 1'b0, 16'h1234);
    tick();
    check("t2_en_we", {30'd0, ram_en, ram_we}, 32'd2);
    check("t2_addr", {16'd0, ram_addr}, 32'h0020);
    check("t2_gnt", {30'd0, gnt_a, gnt_b}, 32'd1);
    tick();
    check("t2_wait", {29'd0, busy, ack_b, ram_en}, 32'd4);
    tick();
    check("t2_ack", {31'd0, ack_b}, 32'd1);
    check("t2_rdata_b", {16'd0, rdata_b}, 32'h1234);
    check("t2_rdata_a", {16'd0, rdata_a}, 32'h0);
    req_b = 1'b0;
    tick();
    check("t2_rdata_hold", {16'd0, rdata_b}, 32'h1234);
    check("t2_ack_pulse", {31'd0, ack_b}, 32'd0);

    // 3: both ports requesting continuously
    req_a = 1'b1; we_a = 1'b1; addr_a = 16'h0040; wdata_a = 16'hAAAA;
    req_b = 1'b1; we_b = 1'b0; addr_b = 16'h0020;
    for (int i = 0; i < 10; i++) begin
`ifdef RAM_ARB_RR_EN
      exp_port = (i % 2 == 1);
`else
      exp_port = (i % 5 == 4);
`endif
      push(exp_port, exp_port ? 1'b0 : 1'b1, 16'h1234);
    end
    a0  = acks;
    cyc = 0;
    while ((acks - a0 < 10) && (cyc < 200)) begin
      tick();
      cyc++;
    end
    req_a = 1'b0;
    req_b = 1'b0;
    check("t3_all_acked", sb.size(), 32'd0);
    check("t3_mem", {16'd0, mem[8'h40]}, 32'hAAAA);
    tick();
    check("t3_idle", {31'd0, busy}, 32'd0);

    // 6: req_a dropped during ACCESS of a write
    req_a = 1'b1; we_a = 1'b1; addr_a = 16'h0050; wdata_a = 16'h5555;
    push(1'b0, 1'b1, 16'h0);
    tick();
    check("t6_access", {31'd0, ram_en}, 32'd1);
    req_a = 1'b0;
    tick();
    check("t6_ack", {31'd0, ack_a}, 32'd1);
    tick();
    check("t6_idle1", {29'd0, busy, ram_en, ack_a}, 32'd0);
    tick();
    check("t6_idle2", {29'd0, busy, ram_en, ack_a}, 32'd0);
    check("t6_mem", {16'd0, mem[8'h50]}, 32'h5555);

    // 5: reset during WAIT of a B read (abandoned: nothing queued)
    req_b = 1'b1; we_b = 1'b0; addr_b = 16'h0020;
    tick();
    check("t5_access", {30'd0, ram_en, gnt_b}, 32'd3);
    tick();
    check("t5_wait", {29'd0, busy, gnt_b, ram_en}, 32'd6);
    #2;
    reset = 1'b0;
    req_b = 1'b0;
    #1;
    check("t5_rst_ctrl", {27'd0, ram_en, ram_we, gnt_b, busy, ack_b}, 32'd0);
    check("t5_rst_rdata_b", {16'd0, rdata_b}, 32'h0);
    #1;
    reset = 1'b1;
    req_a = 1'b1; we_a = 1'b0; addr_a = 16'h0050;
    push(1'b0, 1'b0, 16'h5555);
    tick();
    check("t5_a_access", {16'd0, ram_addr}, 32'h0050);
    check("t5_a_gnt", {30'd0, gnt_a, gnt_b}, 32'd2);
    tick();
    tick();
    check("t5_a_ack", {31'd0, ack_a}, 32'd1);
    check("t5_a_rdata", {16'd0, rdata_a}, 32'h5555);
    req_a = 1'b0;
    tick();
    check("t5_idle", {31'd0, busy}, 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
